mem_port_arbiter: RTL and testbench

Shares the core's single memory port between instruction fetch (IF) and the load/store path of the execute stage (LS). It accepts one request at a time from either side over a valid/ready handshake and drives it onto the memory bus. It holds one transaction outstanding and routes the response back to the requester that issued it. LS has priority; a starvation guard can force an IF grant.

---
 rtl/riscv_mem_pkg.sv | 13 +
 rtl/arb_starve_ctr.sv | 25 ++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared types for the core's memory-port arbiter
package riscv_mem_pkg;
  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;
  typedef enum logic [1:0] {IDLE, REQ, RSP} arb_state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: counts LS grants taken while IF waits and forces an IF grant at the limit
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ls_grant,
  input  logic if_grant,
  input  logic if_pending,
  output logic force_if
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // clear on IF grant or when IF is not waiting, otherwise count LS grants up to the limit
  always_comb begin
    cnt_d = (if_grant || !if_pending) ? '0 :
            (ls_grant && cnt_q != CW'(STARVE_MAX)) ? cnt_q + 1'b1 : cnt_q;
  end
  assign force_if = if_pending && cnt_q == CW'(STARVE_MAX);
  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, LS first;
// define ARB_STARVE_GUARD_EN to add the IF starvation guard.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data
);
  arb_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  mem_req_t   req_q, req_d;
  logic idle, force_if, grant_ls, grant_if, rsp_hit;

  assign idle = state_q == IDLE;

`ifdef ARB_STARVE_GUARD_EN
  // outside IDLE IF is treated as pending so the counter only clears on an idle cycle without IF
  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .ls_grant   (ls_req_ready),
    .if_grant   (if_req_ready),
    .if_pending (if_req_valid || !idle),
    .force_if   (force_if)
  );
`else
  // strict LS priority; the comparison is always false and keeps STARVE_MAX referenced
  assign force_if = STARVE_MAX < 0;
`endif

  assign grant_ls      = ls_req_valid && !force_if;
  assign grant_if      = if_req_valid && (!ls_req_valid || force_if);
  assign ls_req_ready  = rst_n && idle && grant_ls;
  assign if_req_ready  = rst_n && idle && grant_if;
  assign rsp_hit       = rst_n && state_q == RSP && mem_rsp_valid;
  assign if_rsp_valid  = rsp_hit && owner_q == OWN_IF;
  assign ls_rsp_valid  = rsp_hit && owner_q == OWN_LS;
  assign if_rsp_data   = mem_rsp_data;
  assign ls_rsp_data   = mem_rsp_data;
  assign mem_req_valid = state_q == REQ;
  assign mem_addr      = req_q.addr;
  assign mem_we        = req_q.we;
  assign mem_be        = req_q.be;
  assign mem_wdata     = req_q.wdata;

  // accept in IDLE, issue in REQ, wait for the single response in RSP
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    if (idle && (grant_ls || grant_if)) begin
      state_d = REQ;
      owner_d = grant_ls ? OWN_LS : OWN_IF;
      req_d   = grant_ls ? mem_req_t'{addr: ls_addr, we: ls_we, be: ls_be, wdata: ls_wdata}
                         : mem_req_t'{addr: if_addr, we: 1'b0, be: '1, wdata: '0};
    end else if (state_q == REQ && mem_req_ready) begin
      state_d = RSP;
    end else if (state_q == RSP && mem_rsp_valid) begin
      state_d = IDLE;
    end
  end

  // state, owner and latched request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random traffic checked against a transaction-level model
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_addr, if_rsp_data;
  logic        ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid;
  logic [31:0] ls_addr, ls_wdata, ls_rsp_data;
  logic [3:0]  ls_be;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
  logic [3:0]  mem_be;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int SMAX = 4;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_be(ls_be), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // model: one outstanding transaction, whether the bus took it, and who owns it
  bit          busy, sent, c_ls, if_took, ls_took, force_if, e_if, e_ls, e_rsp;
  logic [31:0] c_addr, c_wdata;
  logic        c_we;
  logic [3:0]  c_be;
  int          starve, if_starve_grants;

  initial begin
    busy = 0; sent = 0; starve = 0; if_took = 0; ls_took = 0; if_starve_grants = 0;
    rst_n = 1'b0;
    if_req_valid = 1'b1; if_addr = 32'h100;
    ls_req_valid = 1'b1; ls_addr = 32'h200; ls_we = 1'b1; ls_be = 4'h3; ls_wdata = 32'h1234;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_req_ready", if_req_ready, 0);
    check("rst_ls_req_ready", ls_req_ready, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_fields", {mem_addr, mem_we, mem_be, mem_wdata[26:0]}, 0);
    check("rst_rsp_valid", {if_rsp_valid, ls_rsp_valid}, 0);
    for (int cyc = 0; cyc < 3200; cyc++) begin
      bit starve_mode;
      @(negedge clk);
      starve_mode = cyc >= 3000;
      rst_n = !(!starve_mode && cyc > 10 && $urandom_range(0, 149) == 0);
      if (!if_req_valid || if_took) begin
        if_req_valid = starve_mode || $urandom_range(0, 2) != 0;
        if_addr = $urandom;
      end
      if (!ls_req_valid || ls_took) begin
        ls_req_valid = starve_mode || $urandom_range(0, 1) != 0;
        ls_addr = $urandom; ls_we = 1'($urandom); ls_be = 4'($urandom); ls_wdata = $urandom;
      end
      mem_req_ready = starve_mode || $urandom_range(0, 2) != 0;
      mem_rsp_valid = starve_mode || $urandom_range(0, 2) == 0;
      mem_rsp_data = $urandom;
      #1;
      force_if = GUARD && starve == SMAX && if_req_valid;
      e_ls  = rst_n && !busy && ls_req_valid && !force_if;
      e_if  = rst_n && !busy && if_req_valid && (!ls_req_valid || force_if);
      e_rsp = rst_n && busy && sent && mem_rsp_valid;
      check("if_req_ready", if_req_ready, e_if);
      check("ls_req_ready", ls_req_ready, e_ls);
      check("mem_req_valid", mem_req_valid, rst_n && busy && !sent);
      if (rst_n && busy && !sent)
        check("mem_fields", {mem_addr, mem_we, mem_be, mem_wdata[26:0]},
              {c_addr, c_we, c_be, c_wdata[26:0]});
      if (!rst_n) check("rst_mid_fields", {mem_addr, mem_be}, 0);
      check("if_rsp_valid", if_rsp_valid, e_rsp && !c_ls);
      check("ls_rsp_valid", ls_rsp_valid, e_rsp && c_ls);
      if (e_rsp) check("rsp_data", c_ls ? ls_rsp_data : if_rsp_data, mem_rsp_data);
      if (starve_mode && if_req_ready) if_starve_grants++;
      if_took = e_if;
      ls_took = e_ls;
      if (!rst_n) begin
        busy = 0; sent = 0; starve = 0;
      end else if (!busy) begin
        if (e_if || !if_req_valid) starve = 0;
        else if (e_ls && starve < SMAX) starve++;
        if (e_ls) begin
          busy = 1; sent = 0; c_ls = 1;
          c_addr = ls_addr; c_we = ls_we; c_be = ls_be; c_wdata = ls_wdata;
        end else if (e_if) begin
          busy = 1; sent = 0; c_ls = 0;
          c_addr = if_addr; c_we = 0; c_be = 4'hF; c_wdata = 0;
        end
      end else if (!sent) begin
        sent = mem_req_ready;
      end else if (mem_rsp_valid) begin
        busy = 0;
      end
    end
`ifdef ARB_STARVE_GUARD_EN
    check("starve_if_granted", if_starve_grants > 8, 1);
`else
    check("starve_if_never", if_starve_grants, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
